sonic_ranging_ctrl: RTL and testbench

- Measurement sequencer for the ultrasonic ranging front end of the metal-detector IP.
- Generates the sensor trigger pulse, times the echo pulse and applies a timeout. Compares the result against a proximity threshold and publishes the result to the sonic_ip AXI4-Lite register bank.
- Configuration inputs come from the slave control registers. Result outputs feed the read-only status and result registers.

---
 rtl/sonic_pkg.sv | 17 +
 rtl/sonic_echo_sync.sv | 37 +++
 rtl/sonic_ranging_ctrl.sv | 193 +++++++++++++++++++
 tb/tb_sonic_ranging_ctrl.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/sonic_pkg.sv
// Shared types and default sizes for the ultrasonic ranging sequencer.
package sonic_pkg;

    localparam int CNT_W_DEF  = 24;
    localparam int TRIG_W_DEF = 16;
    localparam int SEQ_W_DEF  = 8;

    typedef enum logic [2:0] {
        IDLE,
        TRIG,
        WAIT_ECHO,
        MEASURE,
        DONE,
        HOLDOFF
    } state_e;

endpackage

// File: rtl/sonic_echo_sync.sv
// Brings the asynchronous sensor echo into the clock domain and flags its edges.
module sonic_echo_sync (
    input  logic clk,
    input  logic rst,
    input  logic echo_in,
    output logic echo_s,
    output logic rise,
    output logic fall
);

    logic s1_q, s1_d;
    logic s2_q, s2_d;
    logic dly_q, dly_d;

    always_comb begin
        s1_d  = echo_in;
        s2_d  = s1_q;
        dly_d = s2_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q  <= 1'b0;
            s2_q  <= 1'b0;
            dly_q <= 1'b0;
        end else begin
            s1_q  <= s1_d;
            s2_q  <= s2_d;
            dly_q <= dly_d;
        end
    end

    assign echo_s = s2_q;
    assign rise   = s2_q & ~dly_q;
    assign fall   = ~s2_q & dly_q;

endmodule

// File: rtl/sonic_ranging_ctrl.sv
// Trigger / echo-timing / holdoff sequencer feeding the sonic_ip result registers.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | waiting for cfg_start or cfg_enable
// TRIG      | trig_out high, trigger down-counter running
// WAIT_ECHO | timer counts up until echo rise or limit
// MEASURE   | echo width counting, saturates at limit
// DONE      | publish result for one cycle
// HOLDOFF   | quiet period down-counter before the next trigger
module sonic_ranging_ctrl
    import sonic_pkg::*;
#(
    parameter int CNT_W  = CNT_W_DEF,
    parameter int TRIG_W = TRIG_W_DEF,
    parameter int SEQ_W  = SEQ_W_DEF
) (
    input  logic              ACLK,
    input  logic              ARESET,
    input  logic              cfg_enable,
    input  logic              cfg_start,
    input  logic [TRIG_W-1:0] cfg_trig_len,
    input  logic [CNT_W-1:0]  cfg_timeout,
    input  logic [CNT_W-1:0]  cfg_holdoff,
    input  logic [CNT_W-1:0]  cfg_threshold,
    input  logic              echo_in,
    output logic              trig_out,
    output logic [CNT_W-1:0]  meas_count,
    output logic              meas_valid,
    output logic              meas_timeout,
    output logic              meas_near,
    output logic              busy,
    output logic [SEQ_W-1:0]  meas_seq
);

    state_e             state_q, state_d;
    logic [TRIG_W-1:0]  trig_q, trig_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [CNT_W-1:0]   limit_q, limit_d;
    logic [CNT_W-1:0]   hold_q, hold_d;
    logic               to_q, to_d;

    logic               trig_out_q, trig_out_d;
    logic [CNT_W-1:0]   meas_count_q, meas_count_d;
    logic               meas_valid_q, meas_valid_d;
    logic               meas_timeout_q, meas_timeout_d;
    logic               meas_near_q, meas_near_d;
    logic [SEQ_W-1:0]   meas_seq_q, meas_seq_d;

    logic               echo_s, rise, fall;
    logic [TRIG_W-1:0]  trig_load;
    logic [CNT_W-1:0]   limit_load;

    sonic_echo_sync u_echo_sync (
        .clk     (ACLK),
        .rst     (ARESET),
        .echo_in (echo_in),
        .echo_s  (echo_s),
        .rise    (rise),
        .fall    (fall)
    );

    assign trig_load  = (cfg_trig_len == '0) ? TRIG_W'(1) : cfg_trig_len;
    assign limit_load = (cfg_timeout == '0) ? '1 : cfg_timeout;

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state_q        <= IDLE;
            trig_q         <= '0;
            cnt_q          <= '0;
            limit_q        <= '0;
            hold_q         <= '0;
            to_q           <= 1'b0;
            trig_out_q     <= 1'b0;
            meas_count_q   <= '0;
            meas_valid_q   <= 1'b0;
            meas_timeout_q <= 1'b0;
            meas_near_q    <= 1'b0;
            meas_seq_q     <= '0;
        end else begin
            state_q        <= state_d;
            trig_q         <= trig_d;
            cnt_q          <= cnt_d;
            limit_q        <= limit_d;
            hold_q         <= hold_d;
            to_q           <= to_d;
            trig_out_q     <= trig_out_d;
            meas_count_q   <= meas_count_d;
            meas_valid_q   <= meas_valid_d;
            meas_timeout_q <= meas_timeout_d;
            meas_near_q    <= meas_near_d;
            meas_seq_q     <= meas_seq_d;
        end
    end

    always_comb begin
        state_d = state_q;
        trig_d  = trig_q;
        cnt_d   = cnt_q;
        limit_d = limit_q;
        hold_d  = hold_q;
        to_d    = to_q;
        case (state_q)
            IDLE: begin
                if (cfg_start || cfg_enable) begin
                    state_d = TRIG;
                    trig_d  = trig_load;
                end
            end
            TRIG: begin
                if (trig_q <= TRIG_W'(1)) begin
                    state_d = WAIT_ECHO;
                    cnt_d   = '0;
                    limit_d = limit_load;
                end else begin
                    trig_d = trig_q - TRIG_W'(1);
                end
            end
            WAIT_ECHO: begin
                // A rise on the same cycle the limit is hit still wins.
                if (rise) begin
                    state_d = MEASURE;
                    cnt_d   = CNT_W'(1);
                end else if (cnt_q == limit_q) begin
                    state_d = DONE;
                    cnt_d   = '0;
                    to_d    = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            MEASURE: begin
                if (fall) begin
                    state_d = DONE;
                    to_d    = 1'b0;
                end else if (echo_s && (cnt_q == limit_q)) begin
                    state_d = DONE;
                    to_d    = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DONE: begin
                if (cfg_holdoff != '0) begin
                    state_d = HOLDOFF;
                    hold_d  = cfg_holdoff;
                end else if (cfg_enable) begin
                    state_d = TRIG;
                    trig_d  = trig_load;
                end else begin
                    state_d = IDLE;
                end
            end
            HOLDOFF: begin
                if (hold_q <= CNT_W'(1)) begin
                    if (cfg_enable) begin
                        state_d = TRIG;
                        trig_d  = trig_load;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    hold_d = hold_q - CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        trig_out_d     = (state_d == TRIG);
        meas_valid_d   = (state_q == DONE);
        meas_count_d   = meas_count_q;
        meas_timeout_d = meas_timeout_q;
        meas_near_d    = meas_near_q;
        meas_seq_d     = meas_seq_q;
        if (state_q == DONE) begin
            meas_count_d   = cnt_q;
            meas_timeout_d = to_q;
            meas_near_d    = (cnt_q < cfg_threshold) && !to_q;
            meas_seq_d     = meas_seq_q + SEQ_W'(1);
        end
    end

    assign trig_out     = trig_out_q;
    assign meas_count   = meas_count_q;
    assign meas_valid   = meas_valid_q;
    assign meas_timeout = meas_timeout_q;
    assign meas_near    = meas_near_q;
    assign meas_seq     = meas_seq_q;
    assign busy         = (state_q != IDLE);

endmodule

// File: tb/tb_sonic_ranging_ctrl.sv
// Directed bench for sonic_ranging_ctrl: vector table plus hand-written corner sequences.
module tb_sonic_ranging_ctrl;

    localparam int CNT_W  = 24;
    localparam int TRIG_W = 16;
    localparam int SEQ_W  = 8;

    logic              ACLK = 1'b0;
    logic              ARESET;
    logic              cfg_enable, cfg_start;
    logic [TRIG_W-1:0] cfg_trig_len;
    logic [CNT_W-1:0]  cfg_timeout, cfg_holdoff, cfg_threshold;
    logic              echo_in;
    logic              trig_out, meas_valid, meas_timeout, meas_near, busy;
    logic [CNT_W-1:0]  meas_count;
    logic [SEQ_W-1:0]  meas_seq;

    sonic_ranging_ctrl #(.CNT_W(CNT_W), .TRIG_W(TRIG_W), .SEQ_W(SEQ_W)) dut (
        .ACLK          (ACLK),
        .ARESET        (ARESET),
        .cfg_enable    (cfg_enable),
        .cfg_start     (cfg_start),
        .cfg_trig_len  (cfg_trig_len),
        .cfg_timeout   (cfg_timeout),
        .cfg_holdoff   (cfg_holdoff),
        .cfg_threshold (cfg_threshold),
        .echo_in       (echo_in),
        .trig_out      (trig_out),
        .meas_count    (meas_count),
        .meas_valid    (meas_valid),
        .meas_timeout  (meas_timeout),
        .meas_near     (meas_near),
        .busy          (busy),
        .meas_seq      (meas_seq)
    );

    always #5 ACLK = ~ACLK;

    typedef struct {
        int trig_len; int timeout; int holdoff; int thr;
        int d; int len;
        int e_trig; int e_count; int e_to; int e_near; int e_lat;
    } vec_t;

    vec_t vecs[10];
    int   checks = 0;
    int   errors = 0;
    int   exp_seq = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic pulse_start();
        @(negedge ACLK);
        cfg_start = 1'b1;
        @(negedge ACLK);
        cfg_start = 1'b0;
    endtask

    // Latency is counted from the first cycle trig_out is low; echo_in is
    // high on lat in [d, d+len).
    task automatic run_vec(input int idx, input vec_t v);
        int tcount, lat, vlat, nvalid, bound;
        logic [31:0] c_cnt, c_to, c_near, c_seq;
        c_cnt = 0; c_to = 0; c_near = 0; c_seq = 0;
        cfg_trig_len  = TRIG_W'(v.trig_len);
        cfg_timeout   = CNT_W'(v.timeout);
        cfg_holdoff   = CNT_W'(v.holdoff);
        cfg_threshold = CNT_W'(v.thr);
        pulse_start();
        tcount = 0;
        while (trig_out === 1'b1 && tcount < 300000) begin
            tcount++;
            @(negedge ACLK);
        end
        check($sformatf("v%0d trig_len", idx), tcount, v.e_trig);
        bound = ((v.d + v.len > v.e_lat) ? v.d + v.len : v.e_lat) + 50;
        lat = 0; nvalid = 0; vlat = -1;
        while (lat < bound && (nvalid == 0 || lat < v.d + v.len)) begin
            echo_in   = (lat >= v.d) && (lat < v.d + v.len);
            cfg_start = (v.e_to == 0) && (v.len >= 4) && (lat == v.d + 4);
            if (meas_valid === 1'b1) begin
                nvalid++;
                if (nvalid == 1) begin
                    vlat   = lat;
                    c_cnt  = 32'(meas_count);
                    c_to   = 32'(meas_timeout);
                    c_near = 32'(meas_near);
                    c_seq  = 32'(meas_seq);
                end
            end
            @(negedge ACLK);
            lat++;
        end
        echo_in = 1'b0;
        cfg_start = 1'b0;
        exp_seq = (exp_seq + 1) % 256;
        check($sformatf("v%0d latency", idx), vlat, v.e_lat);
        check($sformatf("v%0d count", idx), c_cnt, v.e_count);
        check($sformatf("v%0d timeout", idx), c_to, v.e_to);
        check($sformatf("v%0d near", idx), c_near, v.e_near);
        check($sformatf("v%0d seq", idx), c_seq, exp_seq);
        repeat (v.holdoff + 6) begin
            if (meas_valid === 1'b1) nvalid++;
            @(negedge ACLK);
        end
        check($sformatf("v%0d valid pulses", idx), nvalid, 1);
        check($sformatf("v%0d busy idle", idx), 32'(busy), 0);
        check($sformatf("v%0d count held", idx), 32'(meas_count), v.e_count);
    endtask

    initial begin
        int lat, vlat, tcount, nval, cyc, last_v, since, w, bad;
        logic prev_trig;

        vecs[0] = '{1000, 100000, 3,    0, 200,   500, 1000,  500, 0, 0,  704};
        vecs[1] = '{  10,    300, 0, 1000,   0,     0,   10,    0, 1, 0,  302};
        vecs[2] = '{  10,   4000, 0, 5000,  10, 10000,   10, 4000, 1, 0, 4014};
        vecs[3] = '{  10, 100000, 2,  300,  20,   299,   10,  299, 0, 1,  323};
        vecs[4] = '{  10, 100000, 2,  300,  20,   300,   10,  300, 0, 0,  324};
        vecs[5] = '{  10, 100000, 2,  300,  20,   301,   10,  301, 0, 0,  325};
        vecs[6] = '{   5,      0, 0,    8,   3,     7,    5,    7, 0, 1,   14};
        vecs[7] = '{   0, 100000, 1,    2,   0,     1,    1,    1, 0, 1,    5};
        vecs[8] = '{  10,     10, 0,  100,   8,     5,   10,    5, 0, 1,   17};
        vecs[9] = '{  10,     10, 0,  100,   9,     5,   10,    0, 1, 0,   12};

        ARESET = 1'b1; cfg_enable = 1'b0; cfg_start = 1'b0; echo_in = 1'b0;
        cfg_trig_len = '0; cfg_timeout = '0; cfg_holdoff = '0; cfg_threshold = '0;
        repeat (3) @(negedge ACLK);
        check("reset trig_out", 32'(trig_out), 0);
        check("reset meas_count", 32'(meas_count), 0);
        check("reset meas_valid", 32'(meas_valid), 0);
        check("reset meas_timeout", 32'(meas_timeout), 0);
        check("reset meas_near", 32'(meas_near), 0);
        check("reset busy", 32'(busy), 0);
        check("reset meas_seq", 32'(meas_seq), 0);
        ARESET = 1'b0;
        repeat (2) @(negedge ACLK);

        for (int i = 0; i < 10; i++) run_vec(i, vecs[i]);

        // Echo already high before the trigger: no rise, so it times out.
        echo_in = 1'b1;
        cfg_trig_len = 16'd10; cfg_timeout = 24'd50; cfg_holdoff = '0; cfg_threshold = 24'd1000;
        repeat (5) @(negedge ACLK);
        pulse_start();
        tcount = 0;
        while (trig_out === 1'b1 && tcount < 100) begin tcount++; @(negedge ACLK); end
        check("stuck trig_len", tcount, 10);
        lat = 0; vlat = -1;
        while (lat < 200 && vlat < 0) begin
            if (meas_valid === 1'b1) vlat = lat;
            else begin @(negedge ACLK); lat++; end
        end
        exp_seq = (exp_seq + 1) % 256;
        check("stuck latency", vlat, 52);
        check("stuck count", 32'(meas_count), 0);
        check("stuck timeout", 32'(meas_timeout), 1);
        check("stuck near", 32'(meas_near), 0);
        check("stuck seq", 32'(meas_seq), exp_seq);
        echo_in = 1'b0;
        repeat (6) @(negedge ACLK);

        // Reset pulse in the middle of a long trigger.
        cfg_trig_len = 16'd1000; cfg_timeout = 24'd1000; cfg_holdoff = '0;
        pulse_start();
        repeat (3) @(negedge ACLK);
        ARESET = 1'b1;
        @(negedge ACLK);
        ARESET = 1'b0;
        exp_seq = 0;
        check("rst trig_out", 32'(trig_out), 0);
        check("rst busy", 32'(busy), 0);
        check("rst meas_count", 32'(meas_count), 0);
        check("rst meas_timeout", 32'(meas_timeout), 0);
        check("rst meas_near", 32'(meas_near), 0);
        check("rst meas_seq", 32'(meas_seq), 0);
        bad = 0;
        repeat (1100) begin
            if (meas_valid !== 1'b0 || trig_out !== 1'b0 || busy !== 1'b0) bad++;
            @(negedge ACLK);
        end
        check("rst stays idle", bad, 0);
        run_vec(10, vecs[3]);

        // Continuous mode: start and enable together, 256 measurements.
        @(negedge ACLK); ARESET = 1'b1;
        @(negedge ACLK); ARESET = 1'b0;
        exp_seq = 0;
        cfg_trig_len = 16'd10; cfg_timeout = 24'd1000; cfg_holdoff = 24'd50; cfg_threshold = '0;
        @(negedge ACLK);
        cfg_enable = 1'b1; cfg_start = 1'b1;
        @(negedge ACLK);
        cfg_start = 1'b0;
        prev_trig = trig_out; since = 1000; cyc = 0; last_v = -1; nval = 0;
        while (nval < 256 && cyc < 30000) begin
            if (prev_trig && !trig_out) since = 0;
            else if (since < 1000) since++;
            prev_trig = trig_out;
            echo_in = (since >= 5) && (since < 25);
            if (meas_valid === 1'b1) begin
                nval++;
                exp_seq = (exp_seq + 1) % 256;
                check("cont seq", 32'(meas_seq), exp_seq);
                check("cont count", 32'(meas_count), 20);
                if (last_v >= 0) check("cont period", cyc - last_v, 89);
                last_v = cyc;
            end
            if (nval < 256) begin @(negedge ACLK); cyc++; end
        end
        check("cont valid count", nval, 256);
        check("cont seq wrapped", 32'(meas_seq), 0);
        cfg_enable = 1'b0;
        echo_in = 1'b0;
        w = 0;
        while (busy === 1'b1 && w < 200) begin @(negedge ACLK); w++; end
        check("enable drop to idle", w, 50);
        bad = 0;
        repeat (100) begin
            if (trig_out !== 1'b0 || busy !== 1'b0) bad++;
            @(negedge ACLK);
        end
        check("idle after enable drop", bad, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
